controle_lote: RTL and testbench
================================

# controle_lote

Batch initiator for the `projetoFinal` compute engine. It queues up to `N_JOBS` operand sets (A, B, C, K) from a host and issues them to the engine one at a time using the engine's `inicio`/`pronto` handshake. It captures each `resultado` into a result queue that the host drains, and it aborts any job whose `pronto` does not arrive within `TIMEOUT` cycles. It sits between the host/test logic and one engine instance, with the engine on the responder side.

## Interface
- `N_JOBS`, 4: depth of the operand queue and of the result queue; power of two, ≥2.
- `TIMEOUT`, 64: maximum number of cycles spent waiting for `pronto` per job; ≥2.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `carrega` in 1: host write strobe for an operand set; ignored while `cheio`=1.
- `a_in`, `b_in`, `c_in` in 16: operands to enqueue.
- `k_in` in 8: operand K to enqueue.
- `cheio` out 1: operand queue full.
- `A`, `B`, `C` out 16: operands driven to the engine; held stable while `inicio`=1.
- `K` out 8: operand K driven to the engine; held stable while `inicio`=1.
- `inicio` out 1: engine start, level-held until `pronto` is sampled.
- `pronto` in 1: engine done.
- `resultado` in 16: engine result, sampled on the cycle `pronto`=1.
- `ler` in 1: host pop strobe for the result queue; ignored while `vazio`=1.
- `res_out` out 16: head of the result queue (first-word fall-through).
- `vazio` out 1: result queue empty.
- `ocupado` out 1: high in every state other than OCIOSO.
- `erro_timeout` out 1: one-cycle pulse per aborted job.

## Operation
- Operand queue is a FIFO. `carrega`=1 with `cheio`=0 writes {a,b,c,k}.
- State machine states:
  - OCIOSO: go to EMITE when the operand queue is non-empty and the result queue is not full. The dispatch condition reserves the result slot.
  - EMITE: pop the head operand set into the A/B/C/K output registers, then go to AGUARDA. `inicio` rises on entry to AGUARDA.
  - AGUARDA: `inicio`=1 and the timeout counter increments each cycle.
    - `pronto`=1 → push `resultado` into the result queue and go to FOLGA.
    - Counter reaches `TIMEOUT`-1 with `pronto`=0 → go to FOLGA and pulse `erro_timeout`. Nothing is pushed.
  - FOLGA: `inicio`=0 for exactly one cycle so the engine sees a low level, then go to OCIOSO.
- Results leave in issue order; an aborted job leaves no entry.
- Simultaneous `pronto` and timeout on the same cycle: `pronto` wins, the result is stored and there is no error.
- Simultaneous `carrega` and the EMITE pop: both take effect. `cheio` is computed from the post-cycle occupancy.
- Simultaneous `ler` and a result push: both take effect, and occupancy is unchanged.
- `pronto`=1 outside AGUARDA is ignored.
- A/B/C/K keep the last issued values after the job completes.
- All arithmetic is unsigned. Pointers wrap modulo `N_JOBS`, with an extra wrap bit that distinguishes full from empty.

## Timing
- Reset (`rst`=0, asynchronous): state OCIOSO; both queues empty.
  - Output values: `cheio`=0, `vazio`=1, `res_out`=0, `A`/`B`/`C`/`K`=0, `inicio`=0, `ocupado`=0, `erro_timeout`=0.
  - Reset mid-job drops `inicio` immediately and discards all queued operands and results.
- Write to issue: `carrega` at edge n → operand visible at edge n+1 → EMITE at n+2 → `inicio`=1 from n+3.
- Result: `pronto` sampled at edge m → `vazio`=0 and `res_out` valid after edge m+1.
- Job spacing: from one `pronto` to the next `inicio` rise is 4 cycles minimum (FOLGA, OCIOSO, EMITE, then AGUARDA).
- Timeout: with no `pronto`, `inicio` stays high for exactly `TIMEOUT` cycles. `erro_timeout` is high during the first FOLGA cycle.
- Pop: `ler` at edge n advances the head; the new `res_out` is valid after edge n.

## Structure
- Package `controle_lote_pkg`: state encoding (OCIOSO, EMITE, AGUARDA, FOLGA), width constants W_OP=16, W_K=8, W_RES=16, and the packed operand-set width (56).
- Sub-module `fila_sincrona`: parameterized width/depth FIFO with fall-through read and full/empty outputs. It is instantiated twice, at 56 bits and at 16 bits.
- The FSM, timeout counter and output registers live in `controle_lote`.

## Test plan
The bench engine model returns A+B+C+K, with `pronto` rising 5 cycles after `inicio` and held until `inicio` falls.
- Reset release, then load {3,4,6,8} → `inicio` rises 3 cycles after `carrega`; `res_out`=21 and `vazio`=0 one cycle after `pronto`; `ocupado` returns to 0.
- Load 4 sets back-to-back ({1,1,1,1}, {2,2,2,2}, {3,3,3,3}, {4,4,4,4}) → `cheio`=1 after the 4th write; a 5th `carrega` is ignored; results pop in order 4, 8, 12, 16.
- Leave the result queue full with no `ler` and load a 5th set → no `inicio` until one `ler`; issue then resumes.
- Engine model never asserts `pronto` with TIMEOUT=64 → `inicio` is high for 64 cycles, one `erro_timeout` pulse, no result pushed; the next queued job still completes.
- Engine asserts `pronto` exactly on cycle `TIMEOUT`-1 → result stored, `erro_timeout` stays 0.
- Assert `rst`=0 while in AGUARDA → `inicio`=0 immediately, `vazio`=1, `cheio`=0; a late `pronto` after reset is ignored.

Source files
------------

// File: rtl/controle_lote_pkg.sv
// rtl/controle_lote_pkg.sv - shared types and widths for the controle_lote batch initiator
package controle_lote_pkg;
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    EMITE   = 2'd1,
    AGUARDA = 2'd2,
    FOLGA   = 2'd3
  } estado_t;

  localparam int W_OP  = 16;
  localparam int W_K   = 8;
  localparam int W_RES = 16;
  localparam int W_SET = 3 * W_OP + W_K;

  typedef struct packed {
    logic [W_OP-1:0] a;
    logic [W_OP-1:0] b;
    logic [W_OP-1:0] c;
    logic [W_K-1:0]  k;
  } operandos_t;
endpackage

// File: rtl/fila_sincrona.sv
// rtl/fila_sincrona.sv - synchronous fall-through FIFO with full/empty flags
module fila_sincrona #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         cheio,
  output logic         vazio
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push, pop;

  // Extra pointer bit separates full (bits differ) from empty (bits equal).
  always_comb begin
    vazio    = (wr_ptr_q == rd_ptr_q);
    cheio    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push     = wr_en && !cheio;
    pop      = rd_en && !vazio;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    rd_data  = vazio ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/controle_lote.sv
// rtl/controle_lote.sv - queues operand sets, issues them to one engine, collects results
module controle_lote
  import controle_lote_pkg::*;
#(
  parameter int N_JOBS  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             carrega,
  input  logic [W_OP-1:0]  a_in,
  input  logic [W_OP-1:0]  b_in,
  input  logic [W_OP-1:0]  c_in,
  input  logic [W_K-1:0]   k_in,
  output logic             cheio,
  output logic [W_OP-1:0]  A,
  output logic [W_OP-1:0]  B,
  output logic [W_OP-1:0]  C,
  output logic [W_K-1:0]   K,
  output logic             inicio,
  input  logic             pronto,
  input  logic [W_RES-1:0] resultado,
  input  logic             ler,
  output logic [W_RES-1:0] res_out,
  output logic             vazio,
  output logic             ocupado,
  output logic             erro_timeout
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  estado_t          estado_q, estado_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  operandos_t       op_q, op_d;
  logic             inicio_q, inicio_d;
  logic             erro_q, erro_d;
  logic             ocupado_q, ocupado_d;
  logic [W_SET-1:0] op_head;
  logic             op_vazio, res_cheio;
  logic             pop_op, push_res;

  fila_sincrona #(.W(W_SET), .DEPTH(N_JOBS)) u_fila_op (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (carrega),
    .wr_data ({a_in, b_in, c_in, k_in}),
    .rd_en   (pop_op),
    .rd_data (op_head),
    .cheio   (cheio),
    .vazio   (op_vazio)
  );

  fila_sincrona #(.W(W_RES), .DEPTH(N_JOBS)) u_fila_res (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_res),
    .wr_data (resultado),
    .rd_en   (ler),
    .rd_data (res_out),
    .cheio   (res_cheio),
    .vazio   (vazio)
  );

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    inicio_d = inicio_q;
    erro_d   = 1'b0;
    pop_op   = 1'b0;
    push_res = 1'b0;
    case (estado_q)
      // A free result slot at dispatch is the slot this job will fill.
      OCIOSO: if (!op_vazio && !res_cheio) estado_d = EMITE;
      EMITE: begin
        pop_op   = 1'b1;
        op_d     = op_head;
        cnt_d    = '0;
        inicio_d = 1'b1;
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        if (pronto) begin
          push_res = 1'b1;
          inicio_d = 1'b0;
          estado_d = FOLGA;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          erro_d   = 1'b1;
          inicio_d = 1'b0;
          estado_d = FOLGA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FOLGA:   estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q  <= OCIOSO;
      cnt_q     <= '0;
      op_q      <= '0;
      inicio_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      inicio_q  <= inicio_d;
      erro_q    <= erro_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign A            = op_q.a;
  assign B            = op_q.b;
  assign C            = op_q.c;
  assign K            = op_q.k;
  assign inicio       = inicio_q;
  assign erro_timeout = erro_q;
  assign ocupado      = ocupado_q;
endmodule

// File: tb/tb_controle_lote.sv
// tb/tb_controle_lote.sv - directed table-driven bench for controle_lote with a summing engine model
module tb_controle_lote;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        carrega = 1'b0;
  logic [15:0] a_in = '0, b_in = '0, c_in = '0;
  logic [7:0]  k_in = '0;
  logic        cheio;
  logic [15:0] A, B, C;
  logic [7:0]  K;
  logic        inicio;
  logic        pronto;
  logic [15:0] resultado;
  logic        ler = 1'b0;
  logic [15:0] res_out;
  logic        vazio;
  logic        ocupado;
  logic        erro_timeout;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          eng_cnt = 0;
  int          eng_delay = 5;
  logic        eng_pronto = 1'b0;
  logic [15:0] eng_res = '0;
  logic        force_pronto = 1'b0;
  int          run_len = 0;
  int          runs[$];
  int          erro_cnt = 0;

  typedef struct {
    logic [15:0] a, b, c;
    logic [7:0]  k;
    logic [15:0] exp;
  } vec_t;
  vec_t tab[4];

  controle_lote #(.N_JOBS(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .carrega(carrega), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .k_in(k_in), .cheio(cheio), .A(A), .B(B), .C(C), .K(K), .inicio(inicio),
    .pronto(pronto), .resultado(resultado), .ler(ler), .res_out(res_out),
    .vazio(vazio), .ocupado(ocupado), .erro_timeout(erro_timeout)
  );

  always #5 clk = ~clk;

  assign pronto    = eng_pronto | force_pronto;
  assign resultado = eng_res;

  // Engine: pronto after eng_delay cycles of inicio, held until inicio falls.
  always @(negedge clk) begin
    if (inicio) begin
      eng_cnt = eng_cnt + 1;
      if (eng_cnt >= eng_delay) begin
        eng_pronto = 1'b1;
        eng_res    = A + B + C + 16'(K);
      end
    end else begin
      eng_cnt    = 0;
      eng_pronto = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (inicio) run_len = run_len + 1;
    else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    if (erro_timeout) erro_cnt = erro_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic [7:0] k);
    carrega = 1'b1; a_in = a; b_in = b; c_in = c; k_in = k;
    tick();
    carrega = 1'b0;
  endtask

  task automatic pop(input string name, input logic [15:0] exp);
    chk(name, {16'd0, res_out}, {16'd0, exp});
    ler = 1'b1;
    tick();
    ler = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    int exp_runs[8];
    tab[0] = '{16'd1, 16'd1, 16'd1, 8'd1, 16'd4};
    tab[1] = '{16'd2, 16'd2, 16'd2, 8'd2, 16'd8};
    tab[2] = '{16'd3, 16'd3, 16'd3, 8'd3, 16'd12};
    tab[3] = '{16'd4, 16'd4, 16'd4, 8'd4, 16'd16};
    exp_runs = '{5, 64, 5, 5, 5, 5, 5, 64};

    repeat (3) tick();
    chk("rst_cheio", cheio, 0);
    chk("rst_vazio", vazio, 1);
    chk("rst_res_out", res_out, 0);
    chk("rst_A", A, 0);
    chk("rst_K", K, 0);
    chk("rst_inicio", inicio, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_erro", erro_timeout, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Single job: inicio three cycles after carrega.
    load(16'd3, 16'd4, 16'd6, 8'd8);
    chk("lat_c1_inicio", inicio, 0);
    tick();
    chk("lat_c2_inicio", inicio, 0);
    tick();
    chk("lat_c3_inicio", inicio, 1);
    chk("job1_A", A, 3);
    chk("job1_K", K, 8);
    n = 0;
    while (vazio && n < 20) begin tick(); n++; end
    chk("job1_vazio", vazio, 0);
    chk("job1_res", res_out, 21);
    n = 0;
    while (ocupado && n < 20) begin tick(); n++; end
    chk("job1_ocupado", ocupado, 0);
    chk("job1_A_held", A, 3);
    pop("job1_pop", 16'd21);
    chk("job1_empty", vazio, 1);

    // Dummy job that times out while the batch fills the operand queue.
    eng_delay = 1000;
    load(16'd9, 16'd9, 16'd9, 8'd9);
    repeat (2) tick();
    chk("dummy_inicio", inicio, 1);
    for (int i = 0; i < 4; i++) load(tab[i].a, tab[i].b, tab[i].c, tab[i].k);
    chk("batch_cheio", cheio, 1);
    load(16'd7, 16'd7, 16'd7, 8'd7);
    chk("batch_cheio_5th", cheio, 1);
    chk("batch_A_stable", A, 9);
    n = 0;
    while (!erro_timeout && n < 100) begin tick(); n++; end
    chk("timeout_erro", erro_timeout, 1);
    eng_delay = 5;
    chk("timeout_inicio_low", inicio, 0);
    chk("timeout_no_result", vazio, 1);
    repeat (60) tick();
    chk("batch_erro_cnt", erro_cnt, 1);
    chk("batch_cheio_after", cheio, 0);
    chk("batch_ocupado", ocupado, 0);

    // Result queue full: dispatch must stall until one pop.
    load(16'd5, 16'd5, 16'd5, 8'd5);
    hi = 0;
    for (int i = 0; i < 10; i++) begin tick(); hi += inicio; end
    chk("stall_no_inicio", hi, 0);
    chk("stall_ocupado", ocupado, 0);
    pop("batch_pop0", tab[0].exp);
    n = 0;
    while (!inicio && n < 10) begin tick(); n++; end
    chk("stall_resume", inicio, 1);
    repeat (20) tick();
    for (int i = 1; i < 4; i++) pop($sformatf("batch_pop%0d", i), tab[i].exp);
    pop("stall_pop", 16'd20);
    chk("batch_drained", vazio, 1);

    // pronto on the last allowed cycle wins over the timeout.
    eng_delay = 64;
    load(16'd10, 16'd20, 16'd30, 8'd40);
    repeat (80) tick();
    chk("edge_erro_cnt", erro_cnt, 1);
    chk("edge_vazio", vazio, 0);
    pop("edge_res", 16'd100);

    chk("runs_count", runs.size() >= 8, 1);
    for (int i = 0; i < 8 && i < runs.size(); i++)
      chk($sformatf("run%0d_len", i), runs[i], exp_runs[i]);

    // Reset in the middle of AGUARDA.
    eng_delay = 1000;
    load(16'd1, 16'd2, 16'd3, 8'd4);
    load(16'd5, 16'd6, 16'd7, 8'd8);
    repeat (4) tick();
    chk("mid_inicio", inicio, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_inicio", inicio, 0);
    chk("mid_rst_vazio", vazio, 1);
    chk("mid_rst_cheio", cheio, 0);
    chk("mid_rst_A", A, 0);
    force_pronto = 1'b1;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk("late_pronto_vazio", vazio, 1);
    chk("late_pronto_inicio", inicio, 0);
    chk("late_pronto_ocupado", ocupado, 0);
    force_pronto = 1'b0;
    chk("late_erro_cnt", erro_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
